// File: rtl/hit_receiver_if.sv
// Defender hit-resolution bus: opponent attack/position and defender block in,
// health, hurt state and strobes out.
interface hit_receiver_if;
  logic [1:0] opp_attack_phase_in;
  logic [9:0] opp_x_pos_in;
  logic [9:0] own_x_pos_in;
  logic       block_cmd_in;
  logic [7:0] health_out;
  logic [1:0] hurt_state_out;
  logic       move_lock_out;
  logic       hit_pulse;
  logic       block_pulse;
  logic       ko_out;
  logic [7:0] hurt_color_out_332;

  modport master (
    output opp_attack_phase_in, opp_x_pos_in, own_x_pos_in, block_cmd_in,
    input  health_out, hurt_state_out, move_lock_out, hit_pulse, block_pulse,
           ko_out, hurt_color_out_332
  );

  modport slave (
    input  opp_attack_phase_in, opp_x_pos_in, own_x_pos_in, block_cmd_in,
    output health_out, hurt_state_out, move_lock_out, hit_pulse, block_pulse,
           ko_out, hurt_color_out_332
  );
endinterface

// File: rtl/hit_receiver.sv
// Defender-side hit resolver: detects the opponent's active window, resolves
// hit / block / whiff, applies damage and runs the stun timers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// NORMAL    | free to move, can block
// HITSTUN   | recovering from a clean hit, cannot block, timer running
// BLOCKSTUN | recovering from a blocked hit, can block again, timer running
// KO        | health exhausted, ignores all attacks until reset
module hit_receiver #(
  parameter int P_CHAR_W     = 32,
  parameter int P_REACH      = 24,
  parameter int P_MAX_HEALTH = 100,
  parameter int P_HIT_DMG    = 10,
  parameter int P_CHIP_DMG   = 2,
  parameter int P_HITSTUN    = 20,
  parameter int P_BLOCKSTUN  = 12
) (
  input logic         clk_game,
  input logic         reset_n,
  hit_receiver_if.slave hr
);

  localparam int TMR_W = 8;
  localparam logic [1:0] PH_ACTIVE = 2'b10;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'b00,
    ST_HITSTUN   = 2'b01,
    ST_BLOCKSTUN = 2'b10,
    ST_KO        = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [7:0]       health, health_nxt;
  logic [1:0]       prev_phase;
  logic             consumed, consumed_nxt;
  logic             hit_q, hit_nxt;
  logic             block_q, block_nxt;

  logic             active_edge;
  logic             in_range;
  logic             contact;
  logic             blocked;
  logic [7:0]       dmg;
  logic [10:0]      opp_x_w, own_x_w;

  // Widened to 11 bits so an attacker near the right screen edge cannot wrap the hitbox.
  assign opp_x_w = {1'b0, hr.opp_x_pos_in};
  assign own_x_w = {1'b0, hr.own_x_pos_in};
  assign in_range = (own_x_w < opp_x_w + 11'(P_CHAR_W + P_REACH)) &&
                    (own_x_w + 11'(P_CHAR_W) > opp_x_w);

  assign active_edge = (hr.opp_attack_phase_in == PH_ACTIVE) &&
                       (prev_phase != PH_ACTIVE) && !consumed;
  assign contact = active_edge && in_range && (state != ST_KO);
  assign blocked = hr.block_cmd_in &&
                   ((state == ST_NORMAL) || (state == ST_BLOCKSTUN));
  assign dmg = blocked ? 8'(P_CHIP_DMG) : 8'(P_HIT_DMG);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_game) begin
    if (!reset_n) begin
      state      <= ST_NORMAL;
      timer      <= '0;
      health     <= 8'(P_MAX_HEALTH);
      prev_phase <= 2'b00;
      consumed   <= 1'b0;
      hit_q      <= 1'b0;
      block_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      health     <= health_nxt;
      prev_phase <= hr.opp_attack_phase_in;
      consumed   <= consumed_nxt;
      hit_q      <= hit_nxt;
      block_q    <= block_nxt;
    end
  end

  // Next state: contact beats timer expiry, so a hit on the last stun tick reloads.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    health_nxt   = health;
    hit_nxt      = 1'b0;
    block_nxt    = 1'b0;
    consumed_nxt = consumed;

    if (hr.opp_attack_phase_in != PH_ACTIVE) begin
      consumed_nxt = 1'b0;
    end else if (active_edge) begin
      consumed_nxt = 1'b1;
    end

    if (contact) begin
      hit_nxt   = !blocked;
      block_nxt = blocked;
      if (dmg >= health) begin
        health_nxt = 8'd0;
        state_nxt  = ST_KO;
        timer_nxt  = '0;
      end else begin
        health_nxt = health - dmg;
        state_nxt  = blocked ? ST_BLOCKSTUN : ST_HITSTUN;
        timer_nxt  = blocked ? TMR_W'(P_BLOCKSTUN - 1) : TMR_W'(P_HITSTUN - 1);
      end
    end else if ((state == ST_HITSTUN) || (state == ST_BLOCKSTUN)) begin
      if (timer == '0) begin
        state_nxt = ST_NORMAL;
      end else begin
        timer_nxt = timer - 1'b1;
      end
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    hr.health_out     = health;
    hr.hurt_state_out = state;
    hr.move_lock_out  = (state != ST_NORMAL);
    hr.ko_out         = (state == ST_KO);
    hr.hit_pulse      = hit_q;
    hr.block_pulse    = block_q;
    case (state)
      ST_HITSTUN:   hr.hurt_color_out_332 = 8'b1111_1111;
      ST_BLOCKSTUN: hr.hurt_color_out_332 = 8'b1111_1100;
      ST_KO:        hr.hurt_color_out_332 = 8'b0100_1001;
      default:      hr.hurt_color_out_332 = 8'b0000_0000;
    endcase
  end

endmodule

// File: tb/tb_hit_receiver.sv
// Bench for hit_receiver: directed scenarios followed by random play, checked
// against a tick-level reference model; strobes go through a scoreboard queue.
module tb_hit_receiver;

  logic clk_game = 1'b0;
  logic reset_n  = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  hit_receiver_if hif ();

  hit_receiver dut (
    .clk_game (clk_game),
    .reset_n  (reset_n),
    .hr       (hif)
  );

  always #5 clk_game = ~clk_game;
  always @(posedge clk_game) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int cyc;
    int kind;    // 1 clean hit, 2 blocked hit
    int health;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: kind 0 normal, 1 hitstun, 2 blockstun, 3 KO;
  // m_left is the number of stun ticks still to be shown, including the current one.
  int m_health = 100;
  int m_kind   = 0;
  int m_left   = 0;
  int m_prev   = 0;
  bit m_used   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_color(input int k);
    case (k)
      1:       return 8'hFF;
      2:       return 8'hFC;
      3:       return 8'h49;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit rn, input int ph, input int ox, input int wx,
                            input bit blk, output int pulse);
    bit edge_seen, near, blocked;
    int dmg;
    pulse = 0;
    if (!rn) begin
      m_health = 100; m_kind = 0; m_left = 0; m_prev = 0; m_used = 0;
      return;
    end
    edge_seen = (ph == 2) && (m_prev != 2) && !m_used;
    if (ph != 2) m_used = 0;
    else if (edge_seen) m_used = 1;
    near = (wx < ox + 56) && (wx + 32 > ox);
    if (edge_seen && near && m_kind != 3) begin
      blocked = blk && (m_kind == 0 || m_kind == 2);
      dmg     = blocked ? 2 : 10;
      pulse   = blocked ? 2 : 1;
      if (dmg >= m_health) begin
        m_health = 0; m_kind = 3; m_left = 0;
      end else begin
        m_health -= dmg;
        m_kind = blocked ? 2 : 1;
        m_left = blocked ? 12 : 20;
      end
    end else if (m_kind == 1 || m_kind == 2) begin
      m_left--;
      if (m_left == 0) m_kind = 0;
    end
    m_prev = ph;
  endtask

  task automatic tick(input bit rn, input int ph, input int ox, input int wx, input bit blk);
    int   p;
    exp_t e;
    @(negedge clk_game);
    reset_n                 = rn;
    hif.opp_attack_phase_in = 2'(ph);
    hif.opp_x_pos_in        = 10'(ox);
    hif.own_x_pos_in        = 10'(wx);
    hif.block_cmd_in        = blk;
    model_step(rn, ph, ox, wx, blk, p);
    if (p != 0) begin
      e.cyc = cyc + 1; e.kind = p; e.health = m_health;
      sb_q.push_back(e);
    end
    @(posedge clk_game);
    #1;
    chk("hurt_state", int'(hif.hurt_state_out), m_kind);
    chk("health", int'(hif.health_out), m_health);
    chk("move_lock", int'(hif.move_lock_out), (m_kind != 0) ? 1 : 0);
    chk("ko", int'(hif.ko_out), (m_kind == 3) ? 1 : 0);
    chk("color", int'(hif.hurt_color_out_332), exp_color(m_kind));
  endtask

  task automatic idle(input int n, input int ox, input int wx);
    for (int i = 0; i < n; i++) tick(1, 0, ox, wx, 0);
  endtask

  task automatic attack(input int ox, input int wx, input bit blk, input int hold);
    tick(1, 0, ox, wx, blk);
    for (int i = 0; i < hold; i++) tick(1, 2, ox, wx, blk);
  endtask

  task automatic do_reset();
    tick(0, 0, 100, 120, 0);
    tick(0, 0, 100, 120, 0);
  endtask

  // Monitor: every strobe the DUT shows must match the oldest scoreboard entry.
  always @(negedge clk_game) begin
    if (cyc > 0) begin
      if (hif.hit_pulse === 1'b1 && hif.block_pulse === 1'b1)
        chk("both_strobes", 1, 0);
      if (hif.hit_pulse === 1'b1 || hif.block_pulse === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", int'(hif.hit_pulse) * 2 + int'(hif.block_pulse), 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe_kind", hif.hit_pulse ? 1 : 2, e.kind);
          chk("strobe_health", int'(hif.health_out), e.health);
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        chk("missing_strobe", 0, sb_q[0].kind);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    int ph, ox, wx;
    bit blk, rn;

    // 1: clean hit, window held 3 ticks, 20 ticks of hitstun
    do_reset();
    chk("reset_health", int'(hif.health_out), 100);
    chk("reset_state", int'(hif.hurt_state_out), 0);
    attack(100, 120, 0, 3);
    idle(22, 100, 120);
    chk("t1_health", int'(hif.health_out), 90);
    chk("t1_state", int'(hif.hurt_state_out), 0);

    // 2: right range boundary
    do_reset();
    attack(100, 157, 0, 1);
    idle(2, 100, 157);
    chk("t2_out_of_range", int'(hif.health_out), 100);
    attack(100, 155, 0, 1);
    chk("t2_in_range", int'(hif.health_out), 90);

    // 3: block, then a repeat inside blockstun
    do_reset();
    attack(100, 120, 1, 1);
    chk("t3_block", int'(hif.health_out), 98);
    chk("t3_state", int'(hif.hurt_state_out), 2);
    idle(3, 100, 120);
    attack(100, 120, 1, 1);
    chk("t3_reblock", int'(hif.health_out), 96);
    idle(14, 100, 120);

    // 4: KO from health 10, further edges ignored
    do_reset();
    for (int i = 0; i < 9; i++) attack(100, 120, 0, 1);
    chk("t4_pre_ko", int'(hif.health_out), 10);
    attack(100, 120, 0, 1);
    chk("t4_ko", int'(hif.ko_out), 1);
    attack(100, 120, 1, 1);
    attack(100, 120, 0, 2);
    chk("t4_ko_health", int'(hif.health_out), 0);

    // 5: new edge on the tick the hitstun timer reaches zero
    do_reset();
    attack(100, 120, 0, 1);
    idle(19, 100, 120);
    tick(1, 2, 100, 120, 0);
    chk("t5_state", int'(hif.hurt_state_out), 1);
    chk("t5_health", int'(hif.health_out), 80);
    idle(22, 100, 120);

    // 6: reset mid-hitstun at health 50
    do_reset();
    for (int i = 0; i < 5; i++) attack(100, 120, 0, 1);
    chk("t6_pre", int'(hif.health_out), 50);
    tick(0, 2, 100, 120, 0);
    chk("t6_health", int'(hif.health_out), 100);
    chk("t6_state", int'(hif.hurt_state_out), 0);
    chk("t6_color", int'(hif.hurt_color_out_332), 0);

    // 7: attacker at the far right, hitbox beyond 10 bits
    attack(1000, 1020, 0, 1);
    chk("t7_no_wrap", int'(hif.health_out), 90);

    // random play
    ph = 0; ox = 100; wx = 120;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        ox = $urandom_range(0, 1023);
        if ($urandom_range(0, 3) == 0) ox = $urandom_range(960, 1023);
        wx = ox + int'($urandom_range(0, 110)) - 40;
        if (wx < 0) wx = 0;
        if (wx > 1023) wx = 1023;
      end
      if ($urandom_range(0, 2) == 0) ph = $urandom_range(0, 3);
      blk = 1'($urandom_range(0, 1));
      rn  = ($urandom_range(0, 79) != 0);
      tick(rn, ph, ox, wx, blk);
    end

    idle(3, 100, 400);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
